// File: rtl/imem_loader.sv
// ---------------------------------------------------------------------------
// imem_loader : boot-time byte-stream loader for instruction memory.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module imem_loader #(
  parameter int MAX_WORDS = 64,
  parameter int LEN_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [LEN_W-1:0] len_words,
  input  logic             byte_valid,
  input  logic [7:0]       byte_data,
  output logic             byte_ready,
  output logic             we,
  output logic [31:0]      waddr,
  output logic [31:0]      wdata,
  output logic             cpu_hold,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam int               CNT_W   = $clog2(MAX_WORDS + 1);
  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_WORDS);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_WRITE = 3'd2;
  localparam logic [2:0] S_DONE  = 3'd3;
  localparam logic [2:0] S_ERR   = 3'd4;

  logic [2:0]       r_state;
  logic [CNT_W-1:0] r_len;
  logic [CNT_W-1:0] r_word_cnt;
  logic [1:0]       r_byte_cnt;
  logic [23:0]      r_word;
  logic [31:0]      r_waddr;
  logic [31:0]      r_wdata;

  logic             w_len_ok;
  logic [CNT_W-1:0] w_word_cnt_inc;

  assign w_len_ok       = (len_words != '0) && (len_words <= MAX_LEN);
  assign w_word_cnt_inc = r_word_cnt + CNT_W'(1);

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_len      <= '0;
      r_word_cnt <= '0;
      r_byte_cnt <= '0;
      r_word     <= '0;
      r_waddr    <= '0;
      r_wdata    <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE, S_ERR: begin
          if (start) begin
            if (w_len_ok) begin
              r_state    <= S_LOAD;
              r_len      <= len_words[CNT_W-1:0];
              r_word_cnt <= '0;
              r_byte_cnt <= '0;
            end else begin
              r_state <= S_ERR;
            end
          end
        end
        S_LOAD: begin
          if (byte_valid) begin
            r_byte_cnt <= r_byte_cnt + 2'd1;
            case (r_byte_cnt)
              2'd0: r_word[7:0]   <= byte_data;
              2'd1: r_word[15:8]  <= byte_data;
              2'd2: r_word[23:16] <= byte_data;
              default: begin
                // Publish address and data together so they stay stable outside WRITE.
                r_wdata <= {byte_data, r_word};
                r_waddr <= {{(30 - CNT_W){1'b0}}, r_word_cnt, 2'b00};
                r_state <= S_WRITE;
              end
            endcase
          end
        end
        S_WRITE: begin
          r_word_cnt <= w_word_cnt_inc;
          r_byte_cnt <= '0;
          r_state    <= (w_word_cnt_inc == r_len) ? S_DONE : S_LOAD;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign byte_ready = (r_state == S_LOAD);
  assign we         = (r_state == S_WRITE);
  assign busy       = (r_state == S_LOAD) || (r_state == S_WRITE);
  assign done       = (r_state == S_DONE);
  assign err        = (r_state == S_ERR);
  assign cpu_hold   = (r_state != S_DONE);
  assign waddr      = r_waddr;
  assign wdata      = r_wdata;

endmodule

`default_nettype wire

// File: tb/tb_imem_loader.sv
// Scoreboarded bench for imem_loader: expected writes are queued by the stimulus
// and popped by an independent write monitor.
`default_nettype none

module tb_imem_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [15:0] len_words = '0;
  logic        byte_valid = 1'b0;
  logic [7:0]  byte_data = '0;
  logic        byte_ready, we, cpu_hold, busy, done, err;
  logic [31:0] waddr, wdata;

  imem_loader #(.MAX_WORDS(64), .LEN_W(16)) dut (
    .clk(clk), .rst(rst), .start(start), .len_words(len_words),
    .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready),
    .we(we), .waddr(waddr), .wdata(wdata), .cpu_hold(cpu_hold),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int          n_cmp = 0;
  int          n_bad = 0;
  int          n_we  = 0;
  logic [63:0] exp_q[$];
  logic [7:0]  stim[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: actual 0x%08h required 0x%08h", name, act, req);
    end
  endtask

  task automatic push_wr(input logic [31:0] a, input logic [31:0] d);
    exp_q.push_back({a, d});
  endtask

  // Write monitor: every we pulse must match the oldest expected write.
  always @(negedge clk) begin
    logic [63:0] e;
    if (we === 1'b1) begin
      n_we++;
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_write: actual addr 0x%08h data 0x%08h required no write", waddr, wdata);
      end else begin
        e = exp_q.pop_front();
        chk("write_addr", waddr, e[63:32]);
        chk("write_data", wdata, e[31:0]);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input int len);
    start     = 1'b1;
    len_words = 16'(len);
    tick();
    start     = 1'b0;
  endtask

  // Presents one byte and returns the cycle count right after it was accepted.
  task automatic send_byte(input logic [7:0] b, output int acc_cyc);
    logic acc;
    acc        = 1'b0;
    byte_valid = 1'b1;
    byte_data  = b;
    for (int n = 0; n < 50; n++) begin
      acc = byte_ready;
      tick();
      if (acc) break;
    end
    if (!acc) begin
      n_cmp++;
      n_bad++;
      $display("FAIL byte_accept_timeout: actual no accept required accept of 0x%02h", b);
    end
    acc_cyc = cyc;
  endtask

  task automatic wait_done(output int c);
    for (int n = 0; n < 1000; n++) begin
      if (done) break;
      tick();
    end
    c = cyc;
    if (!done) begin
      n_cmp++;
      n_bad++;
      $display("FAIL done_timeout: actual done=%0b required 1", done);
    end
  endtask

  // Start, stream stim[], optionally stall 3 cycles after byte index stall_after.
  // exp_lat counts edges from the first accept edge to the edge entering DONE.
  task automatic run_load(input int len, input int stall_after, input int exp_lat);
    int first, t, c;
    first = 0;
    do_start(len);
    chk("err_after_start", err, 0);
    chk("busy_after_start", busy, 1);
    for (int i = 0; i < stim.size(); i++) begin
      send_byte(stim[i], t);
      if (i == 0) first = t;
      if (i == stall_after) begin
        byte_valid = 1'b0;
        repeat (3) tick();
      end
    end
    byte_valid = 1'b0;
    wait_done(c);
    chk("done_latency", c - first, exp_lat);
    chk("done_flag", done, 1);
    chk("cpu_hold_released", cpu_hold, 0);
    chk("busy_clear", busy, 0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_cpu_hold"}, cpu_hold, 1);
    chk({tag, "_byte_ready"}, byte_ready, 0);
    chk({tag, "_we"}, we, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_err"}, err, 0);
    chk({tag, "_waddr"}, waddr, 32'h0);
    chk({tag, "_wdata"}, wdata, 32'h0);
  endtask

  initial begin
    int t, c, first, we_base;

    rst = 1'b0;
    repeat (2) tick();
    chk_reset_outputs("reset");
    rst = 1'b1;
    tick();
    chk("idle_cpu_hold", cpu_hold, 1);
    chk("idle_byte_ready", byte_ready, 0);

    // Three-word program streamed back-to-back.
    stim = '{8'h13, 8'h05, 8'h50, 8'h00, 8'h93, 8'h05, 8'h10, 8'h00, 8'hB3, 8'h86, 8'hC5, 8'h00};
    push_wr(32'h0, 32'h00500513);
    push_wr(32'h4, 32'h00100593);
    push_wr(32'h8, 32'h00C586B3);
    run_load(3, -1, 14);

    // Same program with a 3-cycle gap after the second byte.
    push_wr(32'h0, 32'h00500513);
    push_wr(32'h4, 32'h00100593);
    push_wr(32'h8, 32'h00C586B3);
    run_load(3, 1, 17);

    // Rejected lengths, then recovery with a one-word load.
    do_start(0);
    chk("len0_err", err, 1);
    chk("len0_cpu_hold", cpu_hold, 1);
    chk("len0_byte_ready", byte_ready, 0);
    chk("len0_done", done, 0);
    do_start(65);
    chk("len65_err", err, 1);
    chk("len65_cpu_hold", cpu_hold, 1);
    chk("len65_byte_ready", byte_ready, 0);
    repeat (2) tick();
    chk("err_holds", err, 1);
    stim = '{8'h6F, 8'h00, 8'h00, 8'h00};
    push_wr(32'h0, 32'h0000006F);
    run_load(1, -1, 4);

    // Full-depth load with an incrementing byte pattern.
    stim.delete();
    for (int i = 0; i < 256; i++) stim.push_back(8'(i));
    for (int w = 0; w < 64; w++)
      push_wr(32'(4 * w), {8'(4 * w + 3), 8'(4 * w + 2), 8'(4 * w + 1), 8'(4 * w)});
    run_load(64, -1, 319);
    chk("full_depth_last_addr", waddr, 32'hFC);

    // Reset after six bytes of a four-word load.
    we_base = n_we;
    do_start(4);
    push_wr(32'h0, 32'h44332211);
    stim = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    foreach (stim[i]) send_byte(stim[i], t);
    byte_valid = 1'b0;
    rst = 1'b0;
    tick();
    chk("midload_writes", n_we - we_base, 1);
    chk_reset_outputs("midload_reset");
    repeat (3) tick();
    rst = 1'b1;
    tick();
    stim = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
    push_wr(32'h0, 32'hD4C3B2A1);
    run_load(1, -1, 4);

    // start during LOAD is ignored; start in DONE reloads.
    push_wr(32'h0, 32'h04030201);
    push_wr(32'h4, 32'h08070605);
    stim = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
    do_start(2);
    first = 0;
    for (int i = 0; i < 8; i++) begin
      send_byte(stim[i], t);
      if (i == 0) first = t;
      if (i == 1) begin
        byte_valid = 1'b0;
        start      = 1'b1;
        len_words  = 16'd1;
        tick();
        start      = 1'b0;
      end
    end
    byte_valid = 1'b0;
    wait_done(c);
    chk("ignored_start_latency", c - first, 10);
    chk("ignored_start_done", done, 1);
    chk("ignored_start_cpu_hold", cpu_hold, 0);
    start      = 1'b1;
    len_words  = 16'd1;
    byte_valid = 1'b1;
    byte_data  = 8'hAA;
    tick();
    start      = 1'b0;
    chk("reload_done_clear", done, 0);
    chk("reload_cpu_hold", cpu_hold, 1);
    chk("reload_busy", busy, 1);
    push_wr(32'h0, 32'hDEADBEEF);
    stim = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
    foreach (stim[i]) send_byte(stim[i], t);
    byte_valid = 1'b0;
    wait_done(c);
    chk("reload_done", done, 1);

    repeat (3) tick();
    chk("pending_writes", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: actual simulation still running required finish");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Boot-time sequencer for the Instruction_Memory write side.
- Accepts a byte stream under a valid/ready handshake and assembles little-endian 32-bit words.
- Writes each word to consecutive word-aligned addresses starting at 0.
- Holds the processor core in reset (cpu_hold) until the programmed word count has been written, then releases it so fetch starts at address 0.

Parameters:
- MAX_WORDS, 64, instruction memory depth in 32-bit words; largest accepted program length.
- LEN_W, 16, width of the len_words input.

Ports:
- clk  input  1  single system clock; all logic on rising edge.
- rst  input  1  synchronous reset, active-low (asserted when 0, sampled on rising clk).
- start  input  1  one-cycle load request; len_words sampled in the same cycle.
- len_words  input  LEN_W  number of 32-bit words to load.
- byte_valid  input  1  byte_data valid.
- byte_data  input  8  program byte, little-endian within each word.
- byte_ready  output  1  loader accepts byte_data this cycle.
- we  output  1  instruction memory write enable, one-cycle pulse per word.
- waddr  output  32  byte address of the write, always word-aligned (bits [1:0] = 0).
- wdata  output  32  assembled instruction word.
- cpu_hold  output  1  1 = core held in reset.
- busy  output  1  load in progress.
- done  output  1  last load completed successfully.
- err  output  1  last start request rejected.

Behaviour:
- Reset (rst=0 at a clk edge):
  - state IDLE.
  - cpu_hold=1; byte_ready=0, we=0, busy=0, done=0, err=0; waddr=0, wdata=0.
  - Word and byte counters cleared.
  - Memory contents are not touched.
- States: IDLE, LOAD, WRITE, DONE, ERR.
- IDLE:
  - byte_ready=0; cpu_hold=1.
  - start with 1 <= len_words <= MAX_WORDS: latch len, clear counters, go to LOAD.
  - start with len_words = 0 or len_words > MAX_WORDS: go to ERR.
- LOAD:
  - busy=1; byte_ready=1.
  - A byte is accepted on a cycle with byte_valid & byte_ready.
  - Byte k (k = 0..3) of the current word goes to wdata bits [8k+7:8k].
  - Acceptance of byte 3 moves to WRITE on the next edge.
  - byte_valid low simply stalls; no timeout.
- WRITE (exactly one cycle):
  - we=1, waddr = word_cnt*4, wdata = assembled word; byte_ready=0.
  - Next: word_cnt increments.
  - If the incremented count equals the latched len, go to DONE; otherwise clear byte_cnt and return to LOAD.
- DONE:
  - done=1, busy=0, cpu_hold=0 (deasserts on the first DONE cycle).
  - A valid start reloads: the next state is LOAD, and done=0, cpu_hold=1 from the next cycle.
  - An invalid start goes to ERR.
- ERR:
  - err=1, cpu_hold=1, busy=0, done=0.
  - Leaves only on a valid start, which moves to LOAD and clears err.
  - Further invalid starts keep ERR.
- Throughput: minimum 5 cycles per word (4 byte-accept cycles + 1 write cycle). An N-word load takes at least 5N cycles from the first accepted byte to DONE.
- start is ignored while in LOAD or WRITE; the latched len and counters are unaffected.
- wdata/waddr hold their last values outside WRITE; only we qualifies them.
- Reset mid-load:
  - Returns immediately to IDLE with cpu_hold=1.
  - A partial word is discarded and no write is issued.
  - Words already written remain in memory.
- Boundary: len_words = MAX_WORDS writes addresses 0 .. 4*(MAX_WORDS-1). waddr never exceeds that.
- A byte presented in the same cycle as start is not accepted, since byte_ready is 0 in IDLE, DONE and ERR.

Test Plan:
- Reset then start, len=3, stream bytes 13 05 50 00 / 93 05 10 00 / B3 86 C5 00 back-to-back -> three we pulses: addr 0x0 data 0x00500513; addr 0x4 data 0x00100593; addr 0x8 data 0x00C586B3. DONE and cpu_hold=0 exactly 15 cycles after the first accepted byte.
- Same load with byte_valid dropped for 3 cycles between bytes 1 and 2 -> identical writes, completion delayed by exactly 3 cycles, no extra we.
- start with len=0, then start with len=MAX_WORDS+1 -> err=1, cpu_hold=1, no byte_ready, no we. Following start with len=1 and bytes 6F 00 00 00 -> err clears, one write 0x0000006F at 0x0, done=1.
- len=MAX_WORDS (64) with an incrementing-pattern stream -> 64 writes, last at waddr 0xFC. No write beyond it; done=1.
- rst=0 after 6 bytes of a len=4 load -> exactly one we issued (addr 0x0). Outputs return to reset values with cpu_hold=1; a fresh load then starts writing again at 0x0.
- start pulsed during LOAD, then again in DONE with len=1 -> first start ignored (count unchanged). Second start reasserts cpu_hold, clears done, and overwrites address 0x0.
